// File: rtl/pa_spsram_64x4_ctrl_pkg.sv
// Shared LSU constants for the 64x4 single-port SRAM initiator: FSM encodings,
// macro geometry and the macro's inactive (active-low) control levels.
package pa_spsram_64x4_ctrl_pkg;

    localparam int LSU_SRAM_AW    = 6;
    localparam int LSU_SRAM_DW    = 4;
    localparam int LSU_SRAM_WEW   = 4;
    localparam int LSU_SRAM_DEPTH = 2 ** LSU_SRAM_AW;

    localparam logic                   SRAM_CEN_OFF  = 1'b1;
    localparam logic                   SRAM_GWEN_OFF = 1'b1;
    localparam logic [LSU_SRAM_WEW-1:0] SRAM_WEN_OFF = '1;

    typedef enum logic [1:0] {
        ST_RST  = 2'b00,
        ST_INIT = 2'b01,
        ST_IDLE = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/pa_spsram_64x4_ctrl.sv
// Initiator for the LSU 64x4 single-port SRAM macro: zero-init sweep after reset
// or clr_req, then one client read/write per cycle with 1-cycle read latency.
module pa_spsram_64x4_ctrl
    import pa_spsram_64x4_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_SRAM_AW,
    parameter int DATA_WIDTH = LSU_SRAM_DW,
    parameter int WE_WIDTH   = LSU_SRAM_WEW,
    parameter int DEPTH      = LSU_SRAM_DEPTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  clr_req,
    input  logic                  req_vld,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WE_WIDTH-1:0]   req_wmask,
    output logic                  req_rdy,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [WE_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  init_done_q, init_done_d;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        rsp_vld_d   = 1'b0;
        req_rdy     = 1'b0;
        sram_cen    = SRAM_CEN_OFF;
        sram_gwen   = SRAM_GWEN_OFF;
        sram_wen    = SRAM_WEN_OFF;
        sram_a      = '0;
        sram_d      = '0;

        case (state_q)
            ST_RST: begin
                state_d     = ST_INIT;
                init_cnt_d  = '0;
                init_done_d = 1'b0;
            end
            ST_INIT: begin
                sram_cen   = 1'b0;
                sram_gwen  = 1'b0;
                sram_wen   = '0;
                sram_a     = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (clr_req) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                req_rdy = 1'b1;
                // Macro samples A/CEN/WEN on the edge, so drive straight from the request.
                if (req_vld) begin
                    if (!req_wr) begin
                        sram_cen  = 1'b0;
                        sram_a    = req_addr;
                        rsp_vld_d = 1'b1;
                    end else if (|req_wmask) begin
                        sram_cen  = 1'b0;
                        sram_gwen = 1'b0;
                        sram_wen  = ~req_wmask;
                        sram_a    = req_addr;
                        sram_d    = req_wdata;
                    end
                end
                if (clr_req) begin
                    state_d     = ST_INIT;
                    init_cnt_d  = '0;
                    init_done_d = 1'b0;
                end
            end
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= ST_RST;
            init_cnt_q  <= '0;
            rsp_vld_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rsp_vld_q   <= rsp_vld_d;
            init_done_q <= init_done_d;
        end
    end

    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdata = rsp_vld_q ? sram_q : '0;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_pa_spsram_64x4_ctrl.sv
// Bench for pa_spsram_64x4_ctrl: behavioural macro on the SRAM port, reference
// memory plus a queue of expected read responses tagged with their arrival cycle.
module tb_pa_spsram_64x4_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req, req_vld, req_wr;
    logic [5:0] req_addr;
    logic [3:0] req_wdata, req_wmask;
    logic       req_rdy, rsp_vld, init_done;
    logic [3:0] rsp_rdata;
    logic [5:0] sram_a;
    logic       sram_cen, sram_gwen;
    logic [3:0] sram_wen, sram_d, sram_q;

    typedef struct {
        logic [3:0] d;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] ref_mem [64];
    logic [3:0] mac_mem [64];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    pa_spsram_64x4_ctrl dut (
        .forever_cpuclk(clk),
        .cpurst_b      (rst_n),
        .clr_req       (clr_req),
        .req_vld       (req_vld),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .req_rdy       (req_rdy),
        .rsp_vld       (rsp_vld),
        .rsp_rdata     (rsp_rdata),
        .init_done     (init_done),
        .sram_a        (sram_a),
        .sram_cen      (sram_cen),
        .sram_gwen     (sram_gwen),
        .sram_wen      (sram_wen),
        .sram_d        (sram_d),
        .sram_q        (sram_q)
    );

    // Macro model: registered inputs, Q holds until the next read.
    initial begin
        sram_q = 4'h0;
        for (int i = 0; i < 64; i++) mac_mem[i] = 4'h9;
    end

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                mac_mem[sram_a] <= (mac_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= mac_mem[sram_a];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard
    always @(negedge clk) begin
        if (rsp_vld) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got data %h at cycle %0d, none expected", rsp_rdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_rdata !== e.d || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL rsp_data: got %h at cycle %0d, want %h at cycle %0d", rsp_rdata, cyc, e.d, e.cyc);
                end
            end
        end else begin
            total++;
            if (rsp_rdata !== 4'h0) begin
                bad++;
                $display("FAIL rsp_rdata_idle: got %h, want 0", rsp_rdata);
            end
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL rsp_missing: no rsp_vld at cycle %0d, want data %h", cyc, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_vld = 1'b0;
        clr_req = 1'b0;
        repeat (n) tick();
    endtask

    // Drive one request (controller assumed in IDLE), update the reference, check macro drive.
    task automatic do_req(input logic wr, input logic [5:0] addr,
                          input logic [3:0] wd, input logic [3:0] wm);
        logic       e_cen, e_gwen;
        logic [3:0] e_wen, e_d;
        logic [5:0] e_a;
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_wmask = wm;
        if (!wr) begin
            exp_q.push_back('{ref_mem[addr], cyc + 1});
            e_cen = 1'b0; e_gwen = 1'b1; e_wen = 4'hF; e_a = addr; e_d = 4'h0;
        end else if (wm != 4'h0) begin
            ref_mem[addr] = (ref_mem[addr] & ~wm) | (wd & wm);
            e_cen = 1'b0; e_gwen = 1'b0; e_wen = ~wm; e_a = addr; e_d = wd;
        end else begin
            e_cen = 1'b1; e_gwen = 1'b1; e_wen = 4'hF; e_a = 6'd0; e_d = 4'h0;
        end
        @(negedge clk);
        total++;
        if (req_rdy !== 1'b1 || sram_cen !== e_cen || sram_gwen !== e_gwen ||
            sram_wen !== e_wen || sram_a !== e_a || sram_d !== e_d) begin
            bad++;
            $display("FAIL sram_drive wr=%b a=%0d: got rdy=%b cen=%b gwen=%b wen=%h a=%0d d=%h, want rdy=1 cen=%b gwen=%b wen=%h a=%0d d=%h",
                     wr, addr, req_rdy, sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
                     e_cen, e_gwen, e_wen, e_a, e_d);
        end
        tick();
    endtask

    task automatic check_rst_state();
        @(negedge clk);
        total++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 4'hF || sram_a !== 6'd0 ||
            sram_d !== 4'h0 || req_rdy !== 1'b0 || init_done !== 1'b0 || rsp_vld !== 1'b0) begin
            bad++;
            $display("FAIL rst_state: got cen=%b gwen=%b wen=%h a=%0d d=%h rdy=%b done=%b vld=%b, want 1 1 f 0 0 0 0 0",
                     sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req_rdy, init_done, rsp_vld);
        end
        tick();
    endtask

    // Called at the start of the first INIT cycle; checks all 64 writes and the handoff to IDLE.
    task automatic check_sweep();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            total++;
            if (sram_a !== 6'(i) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 4'h0 ||
                sram_d !== 4'h0 || req_rdy !== 1'b0 || init_done !== 1'b0) begin
                bad++;
                $display("FAIL sweep_cycle %0d: got a=%0d cen=%b gwen=%b wen=%h d=%h rdy=%b done=%b, want a=%0d 0 0 0 0 0 0",
                         i, sram_a, sram_cen, sram_gwen, sram_wen, sram_d, req_rdy, init_done, i);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (init_done !== 1'b1 || req_rdy !== 1'b1 || sram_cen !== 1'b1) begin
            bad++;
            $display("FAIL sweep_done: got done=%b rdy=%b cen=%b, want 1 1 1", init_done, req_rdy, sram_cen);
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = 4'h0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr_req = 1'b0; req_vld = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 4'h9;
        repeat (3) tick();
        check_rst_state();
        rst_n = 1'b1;
        check_rst_state();
        check_sweep();
    endtask

    task automatic test_write_read();
        do_req(1'b1, 6'd5, 4'hA, 4'hF);
        do_req(1'b0, 6'd5, 4'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_masked_write();
        do_req(1'b1, 6'd7, 4'hF, 4'b0101);
        idle(1);
        do_req(1'b0, 6'd7, 4'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 6'd1, 4'h3, 4'hF);
        do_req(1'b1, 6'd2, 4'h6, 4'hF);
        do_req(1'b1, 6'd3, 4'hC, 4'hF);
        do_req(1'b0, 6'd1, 4'h0, 4'h0);
        do_req(1'b0, 6'd2, 4'h0, 4'h0);
        do_req(1'b0, 6'd3, 4'h0, 4'h0);
        do_req(1'b1, 6'd1, 4'hF, 4'h0);
        do_req(1'b0, 6'd1, 4'h0, 4'h0);
        do_req(1'b1, 6'd63, 4'h8, 4'b1000);
        do_req(1'b0, 6'd63, 4'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_clr();
        do_req(1'b1, 6'd9, 4'hC, 4'hF);
        clr_req = 1'b1;
        do_req(1'b0, 6'd9, 4'h0, 4'h0);
        req_vld = 1'b0;
        clr_req = 1'b0;
        check_sweep();
        do_req(1'b0, 6'd9, 4'h0, 4'h0);
        do_req(1'b0, 6'd5, 4'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_reset_mid_init();
        // Pending read is dropped by reset, so nothing is queued for it.
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd7;
        tick();
        req_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (rsp_vld !== 1'b0 || init_done !== 1'b0 || req_rdy !== 1'b0) begin
            bad++;
            $display("FAIL reset_drop_rsp: got vld=%b done=%b rdy=%b, want 0 0 0", rsp_vld, init_done, req_rdy);
        end
        tick();
        rst_n = 1'b1;
        check_rst_state();
        repeat (30) tick();
        @(negedge clk);
        total++;
        if (sram_a !== 6'd30 || sram_cen !== 1'b0) begin
            bad++;
            $display("FAIL init_cnt_30: got a=%0d cen=%b, want a=30 cen=0", sram_a, sram_cen);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (rsp_vld !== 1'b0 || init_done !== 1'b0 || sram_cen !== 1'b1 || sram_a !== 6'd0) begin
            bad++;
            $display("FAIL reset_mid_init: got vld=%b done=%b cen=%b a=%0d, want 0 0 1 0",
                     rsp_vld, init_done, sram_cen, sram_a);
        end
        tick();
        rst_n = 1'b1;
        check_rst_state();
        check_sweep();
        do_req(1'b0, 6'd30, 4'h0, 4'h0);
        do_req(1'b0, 6'd40, 4'h0, 4'h0);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_back_to_back();
        test_clr();
        test_reset_mid_init();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rsp_drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
